plsc_timer_n: RTL and testbench
===============================

# plsc_timer_n

- Parametrised parallel-load synchronous counter/timer, generalising the 4-bit parallel-load counter to WIDTH bits.
- Adds an explicit run-state machine, one-shot vs. periodic auto-reload modes, a registered done flag, and a combinational terminal-count output for cascading.
- Sits in the timer datapath. It is the building block for programmable interval timers, and multiple instances chain through tc → cten.

## Interface
Parameters:
- WIDTH, 8, counter width in bits; legal range 2–32

Ports:
- clk  in  1  rising-edge clock
- clr_b  in  1  reset, synchronous active-low, clears entire block
- cten  in  1  count enable; counts only in RUN
- load  in  1  parallel load of in, and arm
- in  in  WIDTH  load value; also captured as reload value
- mode  in  1  0 = one-shot, 1 = periodic auto-reload
- dir  in  1  0 = up, 1 = down; present only with PLSC_UPDOWN_EN
- out  out  WIDTH  current count (register output)
- tc  out  1  terminal count, combinational
- done  out  1  one-shot expiry flag, registered

## Operation
- Registers: cnt[WIDTH], rld[WIDTH], state, done.
- States: IDLE, RUN, DONE.
- Terminal value TERM: all-ones when counting up, zero when counting down.
- Step direction: +1 when counting up, −1 when counting down, modulo 2^WIDTH.

Per-edge priority, highest first:
- clr_b = 0: cnt = 0, rld = 0, state = IDLE, done = 0.
- load = 1 (any state): cnt = in, rld = in, state = RUN, done = 0.
- RUN, cten = 1, cnt ≠ TERM: cnt steps one count.
- RUN, cten = 1, cnt = TERM, mode = 1: cnt = rld, stay in RUN.
- RUN, cten = 1, cnt = TERM, mode = 0: cnt holds TERM, state = DONE, done = 1.
- Otherwise: all registers hold.

Terminal count:
- tc = (state == RUN) & cten & ~load & (cnt == TERM).
- tc is a zero-latency combinational output so the next stage's cten sees it in the same cycle.

State behaviour:
- IDLE and DONE ignore cten; out holds.
- done stays high until the next load or reset.
- mode is sampled only at the terminal event, so changing it mid-count is legal.
- dir is sampled every cten cycle. Changing dir mid-run changes TERM immediately, and tc follows the new TERM in the same cycle.

Boundary cases:
- Reload value equal to TERM in periodic mode: tc asserts on every cten cycle and cnt stays at TERM.
- load with cten on the terminal cycle: load wins, tc = 0, no reload, done is not set.
- Reset mid-run: takes effect at the next edge regardless of load or cten.

## Timing
- All state changes happen on the rising clk edge; there are no asynchronous paths.
- out is registered: it reflects load or a count step one edge after the input is sampled.
- tc is combinational from cnt, state, cten, load and dir, valid within the same cycle.
- done rises on the edge that consumes the one-shot terminal event, one cycle after tc.
- Periodic mode with reload value R counting up: tc period = 2^WIDTH − R cten cycles.
- Periodic mode with reload value R counting down: tc period = R + 1 cten cycles.
- Reset values: out = 0, tc = 0, done = 0, state = IDLE.

## Configuration
PLSC_UPDOWN_EN:
- Defined: the dir port exists and down-counting is supported (TERM = 0, step −1).
- Undefined: the dir port is absent, the block counts up only, TERM is all-ones, and no down-count logic is synthesised.

## Test plan
All scenarios use WIDTH = 8 unless stated.

1. Reset: run with cten = 1, then drive clr_b = 0 for one cycle.
   - Required: next cycle out = 0x00, done = 0, tc = 0.
   - Then cten = 1 for 5 cycles: out stays 0x00 (IDLE).
2. Periodic: load in = 0xFC, mode = 1, cten held at 1.
   - Required: out = 0xFC, 0xFD, 0xFE, 0xFF, 0xFC, …
   - tc high only during 0xFF cycles, i.e. once every 4 cycles; done stays 0.
3. One-shot: load in = 0xFE, mode = 0, cten = 1.
   - Required: out 0xFE → 0xFF; tc high for 1 cycle.
   - Next cycle done = 1, out holds 0xFF, tc = 0.
   - Then load in = 0x10: done = 0, out = 0x10, counting resumes.
4. Collision: with out = 0xFF in RUN, assert load = 1 (in = 0x20) together with cten = 1.
   - Required: tc = 0 that cycle, next out = 0x20, done = 0.
5. Cascade: two WIDTH = 4 instances, low.tc → high.cten, both loaded with 0x0, mode = 1, low.cten = 1.
   - Required: high.out increments exactly once per 16 cycles.
   - high.tc first asserts at cycle 255 after load.
6. Down count (PLSC_UPDOWN_EN defined): dir = 1, load 0x03, mode = 1.
   - Required: out = 0x03, 0x02, 0x01, 0x00, 0x03, …
   - tc high in the 0x00 cycles, period 4.

Source files
------------

// File: rtl/plsc_timer_n.sv
// plsc_timer_n: WIDTH-bit parallel-load timer with one-shot / periodic auto-reload; `PLSC_UPDOWN_EN adds the dir port (down-count).
// out and done are registered (one edge); tc is combinational so a following stage can use it as cten in the same cycle.
module plsc_timer_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_b,
  input  logic             cten,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             mode,
`ifdef PLSC_UPDOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] cnt_step;
  logic             at_term;

`ifdef PLSC_UPDOWN_EN
  // dir is not registered: flipping it mid-run moves TERM (and tc) in the same cycle
  assign term     = dir ? '0 : '1;
  assign cnt_step = dir ? (cnt_q - WIDTH'(1)) : (cnt_q + WIDTH'(1));
`else
  assign term     = '1;
  assign cnt_step = cnt_q + WIDTH'(1);
`endif

  assign at_term = (cnt_q == term);
  assign tc      = (state_q == S_RUN) & cten & ~load & at_term;
  assign out     = cnt_q;
  assign done    = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    done_d  = done_q;
    if (load) begin
      cnt_d   = in;
      rld_d   = in;
      state_d = S_RUN;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (cten) begin
            if (!at_term) begin
              cnt_d = cnt_step;
            end else if (mode) begin
              cnt_d = rld_q;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_plsc_timer_n.sv
// Scoreboarded random/directed bench for plsc_timer_n (WIDTH=8) plus a two-stage WIDTH=4 cascade.
module tb_plsc_timer_n;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;
`ifdef PLSC_UPDOWN_EN
  localparam bit HAS_DIR = 1'b1;
`else
  localparam bit HAS_DIR = 1'b0;
`endif

  typedef struct {
    int out;
    bit tc;
    bit done;
    int lo_out;
    int hi_out;
    bit lo_tc;
    bit hi_tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr_b = 1'b0;
  logic       cten = 1'b0;
  logic       load = 1'b0;
  logic [7:0] in = 8'h00;
  logic       mode = 1'b0;
`ifdef PLSC_UPDOWN_EN
  logic       dir = 1'b0;
`endif
  logic [7:0] out;
  logic       tc;
  logic       done;

  logic       casc_clr_b = 1'b0;
  logic       casc_load = 1'b0;
  logic [3:0] casc_in = 4'h0;
  logic [3:0] lo_out, hi_out;
  logic       lo_tc, hi_tc, lo_done, hi_done;

  always #5 clk = ~clk;

  plsc_timer_n #(.WIDTH(8)) u_dut (
    .clk(clk), .clr_b(clr_b), .cten(cten), .load(load), .in(in), .mode(mode),
`ifdef PLSC_UPDOWN_EN
    .dir(dir),
`endif
    .out(out), .tc(tc), .done(done)
  );

  plsc_timer_n #(.WIDTH(4)) u_lo (
    .clk(clk), .clr_b(casc_clr_b), .cten(1'b1), .load(casc_load), .in(casc_in), .mode(1'b1),
`ifdef PLSC_UPDOWN_EN
    .dir(1'b0),
`endif
    .out(lo_out), .tc(lo_tc), .done(lo_done)
  );

  plsc_timer_n #(.WIDTH(4)) u_hi (
    .clk(clk), .clr_b(casc_clr_b), .cten(lo_tc), .load(casc_load), .in(casc_in), .mode(1'b1),
`ifdef PLSC_UPDOWN_EN
    .dir(1'b0),
`endif
    .out(hi_out), .tc(hi_tc), .done(hi_done)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: plain integers, one "phase" per armed/expired condition.
  int   m_cnt = 0;
  int   m_rld = 0;
  int   m_phase = P_IDLE;
  bit   m_done = 1'b0;
  int   casc_n = -1;
  int   cyc = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cycle-sample: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock cycle of stimulus: drive, publish the expectation, advance the model.
  task automatic drv(input bit c_clr_b, input bit ld, input bit ce, input logic [7:0] v,
                     input bit md, input bit dr);
    exp_t e;
    bit   down;
    int   term;
    @(posedge clk);
    #1;
    clr_b = c_clr_b;
    load  = ld;
    cten  = ce;
    in    = v;
    mode  = md;
`ifdef PLSC_UPDOWN_EN
    dir   = dr;
`endif
    casc_load = (cyc == 0);

    down = dr && HAS_DIR;
    term = down ? 0 : 255;
    e.out  = m_cnt;
    e.done = m_done;
    e.tc   = (m_phase == P_RUN) && ce && !ld && (m_cnt == term);
    if (casc_n < 0) begin
      e.lo_out = 0; e.hi_out = 0; e.lo_tc = 1'b0; e.hi_tc = 1'b0;
    end else begin
      e.lo_out = casc_n % 16;
      e.hi_out = (casc_n / 16) % 16;
      e.lo_tc  = (casc_n % 16) == 15;
      e.hi_tc  = (casc_n % 256) == 255;
    end
    exp_q.push_back(e);

    if (!c_clr_b) begin
      m_cnt = 0; m_rld = 0; m_phase = P_IDLE; m_done = 1'b0;
    end else if (ld) begin
      m_cnt = int'(v); m_rld = int'(v); m_phase = P_RUN; m_done = 1'b0;
    end else if (m_phase == P_RUN && ce) begin
      if (m_cnt != term) m_cnt = (m_cnt + (down ? 255 : 1)) % 256;
      else if (md) m_cnt = m_rld;
      else begin
        m_phase = P_DONE; m_done = 1'b1;
      end
    end
    if (cyc == 0) casc_n = 0;
    else if (casc_n >= 0) casc_n++;
    cyc++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out", int'(out), e.out);
        check("tc", int'(tc), int'(e.tc));
        check("done", int'(done), int'(e.done));
        check("lo_out", int'(lo_out), e.lo_out);
        check("hi_out", int'(hi_out), e.hi_out);
        check("lo_tc", int'(lo_tc), int'(e.lo_tc));
        check("hi_tc", int'(hi_tc), int'(e.hi_tc));
        check("casc_done", int'({lo_done, hi_done}), 0);
      end
    end
  end

  initial begin : stim
    bit         r_clr, r_ld, r_ce, r_md, r_dr;
    logic [7:0] r_v;
    int         waited;
    repeat (2) @(posedge clk);
    #1;
    clr_b = 1'b1;
    casc_clr_b = 1'b1;

    // reset mid-run, then cten ignored while IDLE
    drv(1, 1, 1, 8'h10, 1, 0);
    repeat (3) drv(1, 0, 1, 8'h00, 1, 0);
    drv(0, 1, 1, 8'h55, 1, 0);
    repeat (5) drv(1, 0, 1, 8'h00, 1, 0);
    // periodic from 0xFC
    drv(1, 1, 1, 8'hFC, 1, 0);
    repeat (10) drv(1, 0, 1, 8'h00, 1, 0);
    // one-shot from 0xFE, then reload 0x10
    drv(1, 1, 1, 8'hFE, 0, 0);
    repeat (4) drv(1, 0, 1, 8'h00, 0, 0);
    drv(1, 1, 1, 8'h10, 0, 0);
    repeat (3) drv(1, 0, 1, 8'h00, 0, 0);
    // load colliding with the terminal cycle
    drv(1, 1, 1, 8'hFD, 1, 0);
    repeat (2) drv(1, 0, 1, 8'h00, 1, 0);
    drv(1, 1, 1, 8'h20, 1, 0);
    repeat (2) drv(1, 0, 1, 8'h00, 1, 0);
    // reload value equal to TERM
    drv(1, 1, 1, 8'hFF, 1, 0);
    repeat (5) drv(1, 0, 1, 8'h00, 1, 0);
    // down count from 3, then a mid-run direction flip
    drv(1, 1, 1, 8'h03, 1, 1);
    repeat (10) drv(1, 0, 1, 8'h00, 1, 1);
    repeat (4) drv(1, 0, 1, 8'h00, 1, 0);
    drv(1, 1, 1, 8'h02, 0, 1);
    repeat (5) drv(1, 0, 1, 8'h00, 0, 1);

    r_dr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r_clr = ($urandom_range(0, 59) != 0);
      r_ld  = ($urandom_range(0, 11) == 0);
      r_ce  = ($urandom_range(0, 3) != 0);
      r_md  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) r_dr = ~r_dr;
      case ($urandom_range(0, 2))
        0:       r_v = 8'hF8 + 8'($urandom_range(0, 7));
        1:       r_v = 8'($urandom_range(0, 7));
        default: r_v = 8'($urandom_range(0, 255));
      endcase
      drv(r_clr, r_ld, r_ce, r_v, r_md, r_dr);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
